dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port 64-bit data SRAM between the CPU MEM stage and the external debug/loader port. Each cycle it grants one requester, drives the SRAM command, and routes the one-cycle-latency read data back to that requester. The CPU has fixed priority over the external port, and a starvation counter bounds how long the external port can be held off. The block sits between the EX_MEM pipeline register outputs, the external port pins, and the `sram_BW64` instance. It drives `cpu_stall` back to the pipeline enable logic.

## Interface
Parameters:
- `ADDR_W`, 64: address width of both requesters and the SRAM command.
- `DATA_W`, 64: data width.
- `STARVE_MAX`, 4: number of consecutive denied external cycles after which the external port wins. Legal range 1..15.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `arst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: CPU access request (`mem_read_mem | mem_write_mem`).
- `cpu_we` in 1: CPU write (1) or read (0).
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_wdata` in DATA_W: CPU write data.
- `cpu_gnt` out 1: CPU command issued this cycle.
- `cpu_stall` out 1: `cpu_req & ~cpu_gnt`; freezes the pipeline.
- `cpu_rvalid` out 1: CPU read data valid.
- `cpu_rdata` out DATA_W: CPU read data.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_gnt`, `ext_rvalid`, `ext_rdata`: same meanings as the CPU ports, for the external port.
- `ext_lock` in 1: hold the grant on the external port (present only with the macro; see Configuration).
- `mem_addr` out ADDR_W, `mem_wen` out 1, `mem_ren` out 1, `mem_wdata` out DATA_W: SRAM command.
- `mem_rdata` in DATA_W: SRAM read data, valid one cycle after `mem_ren`.

## Operation
- Grant decision is combinational from the requests and the registered state; exactly one of `cpu_gnt`/`ext_gnt` is high, or neither.
- Priority order:
  1. Starvation: `starve_cnt == STARVE_MAX` and `ext_req` → external port.
  2. Otherwise `cpu_req` → CPU.
  3. Otherwise `ext_req` → external port.
- SRAM command comes from the granted requester: `mem_wen = gnt & we`, `mem_ren = gnt & ~we`. With no grant, `mem_wen = mem_ren = 0` and addr/wdata are 0.
- `starve_cnt` (4-bit):
  - Increments, saturating at STARVE_MAX, on cycles with `ext_req & ~ext_gnt`.
  - Clears on `ext_gnt` or `~ext_req`.
- Read-return FSM, state `rd_owner` ∈ {NONE, CPU, EXT}, registered:
  - Next state is CPU on a CPU read grant, EXT on an external read grant, NONE otherwise (including writes).
  - In state CPU: `cpu_rvalid = 1`, `cpu_rdata = mem_rdata`. State EXT is symmetric.
  - Non-owner rdata is driven 0.
- Back-to-back reads from alternating owners are legal. Each return follows its own grant by exactly one cycle.
- A requester must hold req/addr/we/wdata stable until it sees gnt. The CPU guarantees this by stalling on `cpu_stall`.

## Timing
- Reset values:
  - All outputs 0.
  - `rd_owner = NONE`, `starve_cnt = 0`.
  - Reset is asynchronous: a mid-operation assert drops any pending `rvalid` immediately. Any SRAM read in flight is discarded.
- Grant latency 0 cycles (same cycle as req); read data latency 1 cycle after gnt; write completes at the gnt edge.
- Worst-case external wait is STARVE_MAX+1 cycles under continuous CPU requests. Worst-case CPU stall is 1 cycle per starvation event (without lock).
- Simultaneous `cpu_req` and `ext_req` with `starve_cnt < STARVE_MAX`: CPU wins.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - `ext_lock` port exists.
  - While `ext_lock & ext_req`, the external port keeps the grant every cycle regardless of `cpu_req`, so the CPU stalls for the whole burst.
  - Lock is honoured only once `ext_gnt` has been obtained normally; asserting `ext_lock` alone does not preempt the CPU.
  - Locked-held state is one register, cleared when `ext_lock` or `ext_req` drops, and on reset.
- Not defined: no `ext_lock` port and no lock logic; arbitration is purely priority plus starvation.

## Structure
- Shared package `dmem_arb_pkg`: `rd_owner_t` enum (NONE=2'd0, CPU=2'd1, EXT=2'd2) and the starvation counter width constant `STARVE_W = 4`.
- One natural sub-module: `dmem_arb_starve_cnt`, the saturating starvation counter with clear.
- The top level holds grant logic, the `rd_owner` FSM and the output muxes.

## Test plan
- Reset: assert `arst` mid-read (state CPU) → `cpu_rvalid` drops to 0 in the same cycle; all outputs 0; the first post-reset CPU read at addr 0x10 returns its data one cycle after gnt.
- Priority: `cpu_req` (read 0x08) and `ext_req` (read 0x20) both asserted in one cycle → `cpu_gnt = 1`, `ext_gnt = 0`, `mem_addr = 0x08`; next cycle `cpu_rvalid = 1` and `ext_gnt = 1`.
- Starvation, STARVE_MAX=4: `cpu_req` held continuously, `ext_req` raised at cycle 0 → `ext_gnt` in cycle 4, `cpu_stall = 1` only in cycle 4, `starve_cnt` back to 0 in cycle 5.
- Alternating reads: cycle 0 CPU reads 0x00 (data 0xAAAA), cycle 1 ext reads 0x08 (data 0x5555) → cycle 1 `cpu_rdata = 0xAAAA`, cycle 2 `ext_rdata = 0x5555`; the non-owner rvalid stays 0.
- Write then read: CPU writes 0xDEADBEEF to 0x18, next cycle ext reads 0x18 → `ext_rdata = 0xDEADBEEF` and `mem_wen` is high only in the first cycle.
- With `DMEM_ARB_LOCK_EN`: ext granted, `ext_lock` held for 6 cycles with `cpu_req` high throughout → `ext_gnt` for 6 consecutive cycles and `cpu_stall = 1` throughout; CPU granted in the cycle after `ext_lock` falls.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-SRAM arbiter: read-return owner encoding and
// starvation counter width.
package dmem_arb_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    EXT  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating starvation counter: counts consecutive denied external cycles,
// clears on grant or when the request drops.
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int unsigned StarveMax = 4
) (
  input  logic                clk,
  input  logic                arst,
  input  logic                inc_i,
  input  logic                clr_i,
  output logic [STARVE_W-1:0] cnt_o,
  output logic                sat_o
);

  localparam logic [STARVE_W-1:0] MaxCnt = STARVE_W'(StarveMax);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = (cnt_q == MaxCnt);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-SRAM arbiter between the CPU MEM stage and the external debug/loader port.
// Optional external burst lock is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              ext_lock,
`endif
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  rd_owner_t           rd_owner_q, rd_owner_d;
  logic [STARVE_W-1:0] starve_cnt;
  logic                starve_sat;
  logic                lock_hold;

  dmem_arb_starve_cnt #(
    .StarveMax(STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .arst (arst),
    .inc_i(ext_req & ~ext_gnt),
    .clr_i(~ext_req | ext_gnt),
    .cnt_o(starve_cnt),
    .sat_o(starve_sat)
  );

`ifdef DMEM_ARB_LOCK_EN
  // Lock only engages after a normally obtained grant, so ext_lock alone never preempts.
  logic lock_q, lock_d;

  assign lock_d    = ext_lock & ext_req & ext_gnt;
  assign lock_hold = lock_q & ext_lock;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end
`else
  assign lock_hold = 1'b0;
`endif

  // Grants are masked during reset so every output reads 0 while arst is high.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (!arst) begin
      if (ext_req && (starve_sat || lock_hold)) begin
        ext_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (ext_req) begin
        ext_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt & ~arst;

  always_comb begin
    mem_wen    = 1'b0;
    mem_ren    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rd_owner_d = NONE;
    if (cpu_gnt) begin
      mem_wen   = cpu_we;
      mem_ren   = ~cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_we) rd_owner_d = CPU;
    end else if (ext_gnt) begin
      mem_wen   = ext_we;
      mem_ren   = ~ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      if (!ext_we) rd_owner_d = EXT;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_owner_q <= NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_rvalid = (rd_owner_q == CPU);
  assign ext_rvalid = (rd_owner_q == EXT);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural SRAM, read-data scoreboard,
// directed grant/priority/starvation checks (lock burst when DMEM_ARB_LOCK_EN is defined).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [63:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [63:0] ext_addr, ext_wdata, ext_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic        ext_lock;
`endif
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wen, mem_ren;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] cpu_q[$];
  logic [63:0] ext_q[$];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W    (64),
    .DATA_W    (64),
    .STARVE_MAX(4)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_stall (cpu_stall),
    .cpu_rvalid(cpu_rvalid),
    .cpu_rdata (cpu_rdata),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .ext_lock  (ext_lock),
`endif
    .ext_gnt   (ext_gnt),
    .ext_rvalid(ext_rvalid),
    .ext_rdata (ext_rdata),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // One-cycle-latency SRAM model.
  logic [63:0] sram [0:31];
  logic [63:0] sram_rd_q = '0;
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr[7:3]] <= mem_wdata;
    if (mem_ren) sram_rd_q <= sram[mem_addr[7:3]];
  end
  assign mem_rdata = sram_rd_q;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rvalid pops the data expected from the matching grant.
  always @(negedge clk) begin
    if (!arst) begin
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 64'd1, 64'd0);
        else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
      if (ext_rvalid) begin
        if (ext_q.size() == 0) check("ext_rvalid_unexpected", 64'd1, 64'd0);
        else check("ext_rdata", ext_rdata, ext_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic ext_drive(input logic req, input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata);
    ext_req = req; ext_we = we; ext_addr = addr; ext_wdata = wdata;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sram[i] = 64'hFFFF_0000 + 64'(i);
    sram[0] = 64'hAAAA;          // 0x00
    sram[1] = 64'h5555;          // 0x08
    sram[2] = 64'h1111_0010;     // 0x10
    sram[4] = 64'h2020;          // 0x20
    arst = 1'b1;
    cpu_drive(0, 0, 0, 0);
    ext_drive(0, 0, 0, 0);
`ifdef DMEM_ARB_LOCK_EN
    ext_lock = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 64'({cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_wen, mem_ren}),
          64'd0);
    check("rst_data", cpu_rdata | ext_rdata | mem_addr | mem_wdata, 64'd0);
    tick();
    arst = 1'b0;

    // Reset mid-read
    cpu_drive(1, 0, 64'h10, 0);
    @(negedge clk);
    check("pre_rst_gnt", 64'(cpu_gnt), 64'd1);
    check("pre_rst_ren", 64'(mem_ren), 64'd1);
    check("pre_rst_addr", mem_addr, 64'h10);
    cpu_q.push_back(64'h1111_0010);
    tick();
    cpu_drive(0, 0, 0, 0);
    @(negedge clk);
    check("pre_rst_rvalid", 64'(cpu_rvalid), 64'd1);
    #1 arst = 1'b1;
    #1;
    check("arst_rvalid_drop", 64'(cpu_rvalid), 64'd0);
    check("arst_rdata", cpu_rdata, 64'd0);
    check("arst_outs", 64'({cpu_gnt, cpu_stall, ext_gnt, ext_rvalid, mem_wen, mem_ren}), 64'd0);
    tick();
    arst = 1'b0;
    cpu_drive(1, 0, 64'h10, 0);
    @(negedge clk);
    check("post_rst_gnt", 64'(cpu_gnt), 64'd1);
    cpu_q.push_back(64'h1111_0010);
    tick();
    cpu_drive(0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_rvalid", 64'(cpu_rvalid), 64'd1);
    tick();
    @(negedge clk);
    check("idle_rvalid", 64'({cpu_rvalid, ext_rvalid}), 64'd0);

    // Priority: simultaneous requests, CPU first
    tick();
    cpu_drive(1, 0, 64'h08, 0);
    ext_drive(1, 0, 64'h20, 0);
    @(negedge clk);
    check("prio_cpu_gnt", 64'(cpu_gnt), 64'd1);
    check("prio_ext_gnt", 64'(ext_gnt), 64'd0);
    check("prio_addr", mem_addr, 64'h08);
    cpu_q.push_back(64'h5555);
    tick();
    cpu_drive(0, 0, 0, 0);
    @(negedge clk);
    check("prio_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("prio_ext_gnt2", 64'(ext_gnt), 64'd1);
    check("prio_addr2", mem_addr, 64'h20);
    ext_q.push_back(64'h2020);
    tick();
    ext_drive(0, 0, 0, 0);
    @(negedge clk);
    check("prio_ext_rvalid", 64'({ext_rvalid, cpu_rvalid}), 64'b10);

    // Starvation with STARVE_MAX=4
    tick();
    cpu_drive(1, 0, 64'h00, 0);
    ext_drive(1, 0, 64'h08, 0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      if (c == 5) ext_drive(0, 0, 0, 0);
      @(negedge clk);
      if (c == 4) begin
        check("starve_ext_gnt", 64'({ext_gnt, cpu_gnt}), 64'b10);
        check("starve_stall", 64'(cpu_stall), 64'd1);
        ext_q.push_back(64'h5555);
      end else begin
        check("starve_cpu_gnt", 64'({ext_gnt, cpu_gnt}), 64'b01);
        check("starve_no_stall", 64'(cpu_stall), 64'd0);
        cpu_q.push_back(64'hAAAA);
      end
      if (c == 5) check("starve_cnt_clr", 64'(dut.starve_cnt), 64'd0);
    end
    tick();
    cpu_drive(0, 0, 0, 0);
    tick();

    // Alternating owners
    cpu_drive(1, 0, 64'h00, 0);
    @(negedge clk);
    cpu_q.push_back(64'hAAAA);
    tick();
    cpu_drive(0, 0, 0, 0);
    ext_drive(1, 0, 64'h08, 0);
    @(negedge clk);
    check("alt_cpu_rdata", cpu_rdata, 64'hAAAA);
    check("alt_ext_rvalid0", 64'(ext_rvalid), 64'd0);
    check("alt_ext_gnt", 64'(ext_gnt), 64'd1);
    ext_q.push_back(64'h5555);
    tick();
    ext_drive(0, 0, 0, 0);
    @(negedge clk);
    check("alt_ext_rdata", ext_rdata, 64'h5555);
    check("alt_cpu_rvalid0", 64'(cpu_rvalid), 64'd0);

    // Write then read through the other port
    tick();
    cpu_drive(1, 1, 64'h18, 64'hDEAD_BEEF);
    @(negedge clk);
    check("wr_wen", 64'({mem_wen, mem_ren}), 64'b10);
    check("wr_wdata", mem_wdata, 64'hDEAD_BEEF);
    tick();
    cpu_drive(0, 0, 0, 0);
    ext_drive(1, 0, 64'h18, 0);
    @(negedge clk);
    check("rd_wen_low", 64'({mem_wen, mem_ren, cpu_rvalid}), 64'b010);
    ext_q.push_back(64'hDEAD_BEEF);
    tick();
    ext_drive(0, 0, 0, 0);
    @(negedge clk);
    check("wr_rd_ext_rdata", ext_rdata, 64'hDEAD_BEEF);

`ifdef DMEM_ARB_LOCK_EN
    // Lock alone does not preempt; once granted it holds the port.
    tick();
    cpu_drive(1, 0, 64'h00, 0);
    ext_drive(1, 0, 64'h20, 0);
    ext_lock = 1'b1;
    @(negedge clk);
    check("lock_no_preempt", 64'({ext_gnt, cpu_gnt}), 64'b01);
    cpu_q.push_back(64'hAAAA);
    tick();
    cpu_drive(0, 0, 0, 0);
    @(negedge clk);
    check("lock_first_gnt", 64'(ext_gnt), 64'd1);
    ext_q.push_back(64'h2020);
    for (int c = 0; c < 5; c++) begin
      tick();
      cpu_drive(1, 0, 64'h00, 0);
      @(negedge clk);
      check("lock_hold_gnt", 64'({ext_gnt, cpu_gnt}), 64'b10);
      check("lock_stall", 64'(cpu_stall), 64'd1);
      ext_q.push_back(64'h2020);
    end
    tick();
    ext_lock = 1'b0;
    ext_drive(0, 0, 0, 0);
    @(negedge clk);
    check("lock_release_cpu", 64'({ext_gnt, cpu_gnt}), 64'b01);
    cpu_q.push_back(64'hAAAA);
    tick();
    cpu_drive(0, 0, 0, 0);
`endif

    repeat (3) tick();
    check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
    check("ext_q_drained", 64'(ext_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
